// File: rtl/sequenciador_ula_if.sv
// Bus bundle for the microprogrammed ULA sequencer: program load, run control
// and the datapath control lines it drives.
interface sequenciador_ula_if #(
  parameter int unsigned AW = 3
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic          start;
  logic          step_mode;
  logic          avanca;
  logic          EnA;
  logic          EnB;
  logic          Sel;
  logic [1:0]    Op;
  logic [1:0]    OpReg;
  logic          Fim;
  logic          busy;
  logic [AW-1:0] pc;
  logic [2:0]    estado;

  modport master (
    output prog_we, prog_addr, prog_data, start, step_mode, avanca,
    input  EnA, EnB, Sel, Op, OpReg, Fim, busy, pc, estado
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, step_mode, avanca,
    output EnA, EnB, Sel, Op, OpReg, Fim, busy, pc, estado
  );
endinterface

// File: rtl/sequenciador_ula.sv
// Microprogrammed sequencer: steps a small writable program of control words
// and drives EnA/EnB/Sel/Op/OpReg for the A/B register, ULA and shift datapath.
module sequenciador_ula #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  sequenciador_ula_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] opreg;
    logic       sel;
    logic       ena;
    logic       enb;
    logic       last;
  } word_t;

  localparam int unsigned WORD_W = 8;
  localparam logic [AW-1:0] PC_MAX = AW'(DEPTH - 1);

  state_t        state_q, state_n;
  logic [AW-1:0] pc_q, pc_n;
  word_t         ir_q, ir_n;
  word_t         mem [DEPTH];

  logic          ena_q, enb_q, sel_q, fim_q, busy_q;
  logic [1:0]    op_q, opreg_q;
  logic          ena_n, enb_n, sel_n, fim_n, busy_n;
  logic [1:0]    op_n, opreg_n;

  // Next state, pc and ir; outputs precomputed from next values so they register cleanly
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    ir_n    = ir_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_n = FETCH;
          pc_n    = '0;
        end
      end
      FETCH: begin
        ir_n    = mem[pc_q];
        state_n = EXEC;
      end
      EXEC: begin
        if (ir_q.last || (pc_q == PC_MAX)) begin
          state_n = DONE;
        end else begin
          pc_n    = AW'(pc_q + 1'b1);
          state_n = bus.step_mode ? WAIT : FETCH;
        end
      end
      WAIT: begin
        if (bus.avanca) state_n = FETCH;
      end
      DONE: begin
        if (!bus.start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    ena_n   = 1'b0;
    enb_n   = 1'b0;
    sel_n   = 1'b0;
    op_n    = 2'b00;
    opreg_n = 2'b00;
    if (state_n == EXEC) begin
      ena_n   = ir_n.ena;
      enb_n   = ir_n.enb;
      sel_n   = ir_n.sel;
      op_n    = ir_n.op;
      opreg_n = ir_n.opreg;
    end
    fim_n  = (state_n == DONE);
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ena_q   <= 1'b0;
      enb_q   <= 1'b0;
      sel_q   <= 1'b0;
      op_q    <= 2'b00;
      opreg_q <= 2'b00;
      fim_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      ir_q    <= ir_n;
      ena_q   <= ena_n;
      enb_q   <= enb_n;
      sel_q   <= sel_n;
      op_q    <= op_n;
      opreg_q <= opreg_n;
      fim_q   <= fim_n;
      busy_q  <= busy_n;
    end
  end

  // Program store; loads only while idle so a running sequence is never disturbed
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.prog_we && (state_q == IDLE)) begin
      mem[bus.prog_addr] <= word_t'(WORD_W'(bus.prog_data));
    end
  end

  assign bus.EnA    = ena_q;
  assign bus.EnB    = enb_q;
  assign bus.Sel    = sel_q;
  assign bus.Op     = op_q;
  assign bus.OpReg  = opreg_q;
  assign bus.Fim    = fim_q;
  assign bus.busy   = busy_q;
  assign bus.pc     = pc_q;
  assign bus.estado = 3'(state_q);

endmodule
